uart_tx: RTL

- UART transmitter. Serialises a parallel byte onto a single line: one start bit, DATA_BITS data bits LSB first, an optional parity bit, then the stop period.
- Timing comes from the 16x oversampling tick produced by baud_rate_gen (clk_out). This is the same tick that drives UART_RX, so uart_tx is the transmit-side counterpart and pairs with UART_RX for loopback.
- Sits between the system-side producer (tx_start/tx_din handshake) and the serial pin.

---
 rtl/uart_tx.sv | 134 +++++++++++++
 1 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_BITS data bits LSB first, optional parity, stop period.
// Bit timing is taken from a 16x-baud single-cycle enable shared with the receiver.
module uart_tx #(
  parameter int DATA_BITS      = 8,
  parameter int STOP_BIT_TICKS = 16,
  parameter bit PARITY_EN      = 1'b0,
  parameter bit PARITY_ODD     = 1'b0
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 tx_sampling_clk,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_din,
  output logic                 tx_out,
  output logic                 tx_busy,
  output logic                 tx_done_tick
);

  localparam int TW = ($clog2(STOP_BIT_TICKS) > 4) ? $clog2(STOP_BIT_TICKS) : 4;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state;
  logic [TW-1:0]          tick_cnt;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   parity_bit;

  wire bit_end  = (tick_cnt == TW'(15));
  wire stop_end = (tick_cnt == TW'(STOP_BIT_TICKS - 1));
  wire last_bit = (bit_cnt == BW'(DATA_BITS - 1));

  // NOTE: every register here is updated with <= so all reads in this block see
  // the values from before the edge; mixing in = would make results order-dependent.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the datapath is small and reset as well, so a reset mid-frame leaves
      // no stale byte behind; tx_out resets high so the line never glitches low.
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      parity_bit   <= 1'b0;
      tx_out       <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx_done_tick <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_out  <= 1'b1;
          tx_busy <= 1'b0;
          if (tx_start) begin
            shift_reg  <= tx_din;
            parity_bit <= (^tx_din) ^ PARITY_ODD;
            tick_cnt   <= '0;
            tx_out     <= 1'b0;
            tx_busy    <= 1'b1;
            state      <= START;
          end
        end

        START: begin
          if (tx_sampling_clk) begin
            if (bit_end) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              tx_out   <= shift_reg[0];
              state    <= DATA;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        DATA: begin
          if (tx_sampling_clk) begin
            if (bit_end) begin
              tick_cnt  <= '0;
              shift_reg <= shift_reg >> 1;
              if (last_bit) begin
                if (PARITY_EN) begin
                  tx_out <= parity_bit;
                  state  <= PARITY;
                end else begin
                  tx_out <= 1'b1;
                  state  <= STOP;
                end
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
                tx_out  <= shift_reg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        PARITY: begin
          if (tx_sampling_clk) begin
            if (bit_end) begin
              tick_cnt <= '0;
              tx_out   <= 1'b1;
              state    <= STOP;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        STOP: begin
          tx_out <= 1'b1;
          // The done pulse is emitted while still in STOP, so a tx_start coinciding
          // with it is ignored and only accepted on the following cycle.
          if (tx_done_tick) begin
            state <= IDLE;
          end else if (tx_sampling_clk) begin
            if (stop_end) begin
              tick_cnt     <= '0;
              tx_done_tick <= 1'b1;
              tx_busy      <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
